// File: rtl/mt_barrel_core.sv
// N-thread fine-grained interleaved core: F/D/X/W pipeline, round-robin fetch,
// per-thread PC/register bank/halt, taken-branch squash and W->D register bypass.
module mt_barrel_core #(
  parameter int NUM_THREADS = 4,
  parameter int DATA_W      = 16,
  parameter int PC_W        = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_THREADS-1:0]           thread_en,
  output logic [PC_W-1:0]                  imem_addr,
  input  logic [15:0]                      imem_rdata,
  output logic                             fetch_valid,
  output logic [$clog2(NUM_THREADS)-1:0]   fetch_tid,
  output logic [NUM_THREADS-1:0]           halted,
  output logic [31:0]                      cycle_count,
  output logic [32*NUM_THREADS-1:0]        retire_count
);
  localparam int TID_W = $clog2(NUM_THREADS);
  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                         OP_OR  = 4'd4, OP_LDI = 4'd5, OP_BNZ = 4'd6, OP_HALT = 4'd7;

  typedef struct packed {
    logic [TID_W-1:0] tid;
    logic [15:0]      ins;
  } ifid_t;

  typedef struct packed {
    logic [TID_W-1:0]  tid;
    logic [3:0]        op;
    logic [3:0]        rd;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [7:0]        imm;
    logic [7:0]        tgt;
  } idex_t;

  typedef struct packed {
    logic [TID_W-1:0]  tid;
    logic [3:0]        op;
    logic [3:0]        rd;
    logic [DATA_W-1:0] res;
    logic [7:0]        tgt;
    logic              taken;
  } exwb_t;

  logic [PC_W-1:0]        pc [NUM_THREADS];
  logic [DATA_W-1:0]      rf [NUM_THREADS][16];
  logic [31:0]            rc [NUM_THREADS];
  logic [TID_W-1:0]       ptr, last_tid, sel, idx;
  logic                   last_vld, any;
  logic [NUM_THREADS-1:0] elig;
  logic [3:1]             vld_pipe;
  ifid_t                  fd;
  idex_t                  dx, dx_d;
  exwb_t                  xw, xw_d;
  logic                   redir, wb_en;

  // A thread fetched last cycle sits out one slot; this spacing makes the bypass sufficient.
  always_comb begin
    elig = '0;
    for (int t = 0; t < NUM_THREADS; t++)
      elig[t] = thread_en[t] && !halted[t] && !(last_vld && last_tid == TID_W'(t));
  end

  always_comb begin
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      idx = ptr + TID_W'(i);
      if (!any && elig[idx]) begin
        sel = idx;
        any = 1'b1;
      end
    end
  end

  assign fetch_valid = any && !rst;
  assign fetch_tid   = rst ? '0 : sel;
  assign imem_addr   = rst ? '0 : pc[sel];
  assign redir       = vld_pipe[3] && (xw.taken || xw.op == OP_HALT);
  assign wb_en       = vld_pipe[3] && xw.op >= OP_ADD && xw.op <= OP_LDI;

  // Decode: opcodes 8..15 collapse to NOP so nothing downstream sees them.
  always_comb begin
    dx_d     = '0;
    dx_d.tid = fd.tid;
    dx_d.op  = fd.ins[15] ? OP_NOP : fd.ins[15:12];
    dx_d.rd  = fd.ins[11:8];
    dx_d.imm = fd.ins[7:0];
    dx_d.tgt = {fd.ins[11:8], fd.ins[3:0]};
    dx_d.a   = (wb_en && xw.tid == fd.tid && xw.rd == fd.ins[7:4]) ? xw.res : rf[fd.tid][fd.ins[7:4]];
    dx_d.b   = (wb_en && xw.tid == fd.tid && xw.rd == fd.ins[3:0]) ? xw.res : rf[fd.tid][fd.ins[3:0]];
  end

  always_comb begin
    xw_d     = '0;
    xw_d.tid = dx.tid;
    xw_d.op  = dx.op;
    xw_d.rd  = dx.rd;
    xw_d.tgt = dx.tgt;
    case (dx.op)
      OP_ADD:  xw_d.res = dx.a + dx.b;
      OP_SUB:  xw_d.res = dx.a - dx.b;
      OP_AND:  xw_d.res = dx.a & dx.b;
      OP_OR:   xw_d.res = dx.a | dx.b;
      OP_LDI:  xw_d.res = DATA_W'(dx.imm);
      OP_BNZ:  xw_d.taken = (dx.a != '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
      ptr         <= TID_W'(NUM_THREADS - 1);
      last_tid    <= '0;
      last_vld    <= 1'b0;
      vld_pipe    <= '0;
      fd          <= '0;
      dx          <= '0;
      xw          <= '0;
      halted      <= '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
        pc[t] <= '0;
        rc[t] <= '0;
        for (int r = 0; r < 16; r++) rf[t][r] <= '0;
      end
    end else begin
      cycle_count <= cycle_count + 32'd1;
      last_vld    <= any;
      last_tid    <= sel;
      if (any) ptr <= sel;
      vld_pipe[1] <= any && !(redir && xw.tid == sel);
      fd.tid      <= sel;
      fd.ins      <= imem_rdata;
      vld_pipe[2] <= vld_pipe[1] && !(redir && xw.tid == fd.tid);
      dx          <= dx_d;
      vld_pipe[3] <= vld_pipe[2];
      xw          <= xw_d;
      // Redirect owns the PC: taken branch loads the target, HALT freezes it.
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (redir && xw.tid == TID_W'(t)) begin
          if (xw.taken) pc[t] <= PC_W'(xw.tgt);
        end else if (any && sel == TID_W'(t)) begin
          pc[t] <= pc[t] + PC_W'(1);
        end
      end
      if (wb_en) rf[xw.tid][xw.rd] <= xw.res;
      if (vld_pipe[3] && xw.op != OP_NOP) rc[xw.tid] <= rc[xw.tid] + 32'd1;
      if (redir && xw.op == OP_HALT) halted[xw.tid] <= 1'b1;
    end
  end

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_rc
    assign retire_count[32*t +: 32] = rc[t];
  end
endmodule

// File: tb/tb_mt_barrel_core.sv
// Scoreboarded bench for mt_barrel_core: expected fetches are queued by the
// stimulus; a negedge monitor pops and compares every issued fetch.
module tb_mt_barrel_core;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   thread_en = '0;
  logic [7:0]     imem_addr;
  logic [15:0]    imem_rdata;
  logic           fetch_valid;
  logic [1:0]     fetch_tid;
  logic [N-1:0]   halted;
  logic [31:0]    cycle_count;
  logic [32*N-1:0] retire_count;

  logic [15:0] mem [N][256];

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  tid;
    logic [7:0]  addr;
  } fe_t;

  fe_t exp_q[$];
  fe_t mon_got, mon_want;
  int  n_chk = 0;
  int  n_fail = 0;
  int  exp_pc [N];
  int  rot [3] = '{3, 0, 1};

  mt_barrel_core #(.NUM_THREADS(N), .DATA_W(16), .PC_W(8)) dut (
    .clk(clk), .rst(rst), .thread_en(thread_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .fetch_valid(fetch_valid), .fetch_tid(fetch_tid),
    .halted(halted), .cycle_count(cycle_count), .retire_count(retire_count)
  );

  // Per-thread program images; the DUT just sees a combinational memory.
  assign imem_rdata = mem[fetch_tid][imem_addr];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (fetch_valid === 1'b1) begin
      mon_got = '{cyc: cycle_count, tid: fetch_tid, addr: imem_addr};
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL fetch: unexpected cyc=%0d tid=%0d addr=%0h", cycle_count, fetch_tid, imem_addr);
      end else begin
        mon_want = exp_q.pop_front();
        chk("fetch {cyc,tid,addr}", 64'(mon_got), 64'(mon_want));
      end
    end
  end

  task automatic clear_mem();
    for (int t = 0; t < N; t++)
      for (int a = 0; a < 256; a++) mem[t][a] = 16'h0000;
  endtask

  task automatic push(input int cyc, input int tid, input int addr);
    exp_q.push_back('{cyc: 32'(cyc), tid: 2'(tid), addr: 8'(addr)});
  endtask

  task automatic start(input logic [N-1:0] en);
    thread_en = en;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic stop();
    chk("queue drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    rst = 1'b1;
  endtask

  task automatic load_branch();
    clear_mem();
    mem[0][0] = 16'h5101; mem[0][1] = 16'h6110; mem[0][2] = 16'h54FF;
    mem[0][16] = 16'h5507; mem[0][17] = 16'h7000;
    mem[1][0] = 16'h5600; mem[1][1] = 16'h6360; mem[1][2] = 16'h572A; mem[1][3] = 16'h7000;
  endtask

  initial begin
    thread_en = '1;
    clear_mem();
    repeat (2) @(posedge clk);
    #1;
    chk("reset fetch_valid", 64'(fetch_valid), 64'd0);
    chk("reset fetch_tid", 64'(fetch_tid), 64'd0);
    chk("reset imem_addr", 64'(imem_addr), 64'd0);
    chk("reset halted", 64'(halted), 64'd0);
    chk("reset cycle_count", 64'(cycle_count), 64'd0);
    chk("reset retire_count", 64'(|retire_count), 64'd0);

    // Isolation: same program on all four threads.
    for (int t = 0; t < N; t++) begin
      mem[t][0] = 16'h5112; mem[t][1] = 16'h5203; mem[t][2] = 16'h1312; mem[t][3] = 16'h7000;
    end
    for (int c = 0; c < 16; c++) push(c, c % 4, c / 4);
    push(16, 1, 4); push(17, 2, 4); push(18, 3, 4);
    start(4'hF);
    run(22);
    chk("iso halted", 64'(halted), 64'hF);
    for (int t = 0; t < N; t++) begin
      chk("iso retire", 64'(retire_count[32*t +: 32]), 64'd4);
      chk("iso r3", 64'(dut.rf[t][3]), 64'h15);
    end
    stop();

    // Single thread: fetch every other cycle, ADD needs the bypass.
    clear_mem();
    mem[0][0] = 16'h5105; mem[0][1] = 16'h1211; mem[0][2] = 16'h7000;
    push(0, 0, 0); push(2, 0, 1); push(4, 0, 2); push(6, 0, 3);
    start(4'b0001);
    run(12);
    chk("single halted", 64'(halted), 64'h1);
    chk("single retire", 64'(retire_count[31:0]), 64'd3);
    chk("single r2 bypass", 64'(dut.rf[0][2]), 64'h000A);
    stop();

    // Taken branch on thread 0, not-taken branch on thread 1.
    load_branch();
    push(0, 0, 0); push(1, 1, 0); push(2, 0, 1); push(3, 1, 1); push(4, 0, 2);
    push(5, 1, 2); push(6, 0, 16); push(7, 1, 3); push(8, 0, 17); push(9, 1, 4); push(10, 0, 18);
    start(4'b0011);
    run(14);
    chk("br halted", 64'(halted), 64'h3);
    chk("br r4 squashed", 64'(dut.rf[0][4]), 64'h0);
    chk("br r5", 64'(dut.rf[0][5]), 64'h7);
    chk("br retire t0", 64'(retire_count[31:0]), 64'd4);
    chk("br retire t1", 64'(retire_count[63:32]), 64'd4);
    chk("br r7 fallthrough", 64'(dut.rf[1][7]), 64'h2A);
    chk("br retire t2", 64'(retire_count[95:64]), 64'd0);
    stop();

    // Halt isolation: thread 2 halts, the rest keep rotating without its slot.
    clear_mem();
    mem[2][2] = 16'h7000;
    for (int t = 0; t < N; t++) exp_pc[t] = 0;
    for (int c = 0; c < 22; c++) begin
      int tid;
      tid = (c < 14) ? (c % 4) : rot[(c - 14) % 3];
      push(c, tid, exp_pc[tid]);
      exp_pc[tid]++;
    end
    start(4'hF);
    run(22);
    chk("halt halted", 64'(halted), 64'h4);
    chk("halt retire t2", 64'(retire_count[95:64]), 64'd1);
    chk("halt retire t0 nops", 64'(retire_count[31:0]), 64'd0);
    stop();

    // Reset while the taken BNZ sits in X/W.
    load_branch();
    push(0, 0, 0); push(1, 1, 0); push(2, 0, 1); push(3, 1, 1); push(4, 0, 2);
    start(4'b0011);
    run(5);
    chk("mid pre-reset retire t0", 64'(retire_count[31:0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("mid fetch_valid", 64'(fetch_valid), 64'd0);
    chk("mid fetch_tid", 64'(fetch_tid), 64'd0);
    chk("mid imem_addr", 64'(imem_addr), 64'd0);
    chk("mid halted", 64'(halted), 64'd0);
    chk("mid cycle_count", 64'(cycle_count), 64'd0);
    chk("mid retire_count", 64'(|retire_count), 64'd0);
    chk("mid r1 cleared", 64'(dut.rf[0][1]), 64'd0);
    chk("mid queue drained", 64'(exp_q.size()), 64'd0);
    push(0, 0, 0); push(1, 1, 0);
    start(4'b0011);
    run(2);
    stop();
    run(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mt_barrel_core.md
Name: mt_barrel_core

Overview:
- Parametrised N-thread fine-grained interleaved core: the successor to the 2-thread core.
- Four stages: F, D, X, W.
- Features:
  - round-robin thread scheduling over an enable mask
  - per-thread PC, register bank and halt state
  - taken-branch squash for any thread count
  - write-through register bypass
  - per-thread retirement counters
- Instruction memory is external, with a combinational read.

Parameters:
- NUM_THREADS, 4, hardware threads; 2..8; power of two.
- DATA_W, 16, register/ALU width; >= 8.
- PC_W, 8, PC width; PCs wrap modulo 2^PC_W.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- thread_en  in  NUM_THREADS  per-thread fetch enable; sampled every cycle.
- imem_addr  out  PC_W  fetch PC of the selected thread.
- imem_rdata  in  16  instruction at imem_addr, same cycle.
- fetch_valid  out  1  a fetch is issued this cycle.
- fetch_tid  out  log2(NUM_THREADS)  thread being fetched.
- halted  out  NUM_THREADS  thread has retired HALT.
- cycle_count  out  32  cycles since reset.
- retire_count  out  32*NUM_THREADS  retired instructions; thread t occupies bits [32t+31:32t].

Behaviour:
- Encoding:
  - op[15:12], rd[11:8], rs1[7:4], rs2[3:0].
  - NOP=0, ADD=1, SUB=2, AND=3, OR=4, LDI=5, BNZ=6, HALT=7; codes 8..15 execute as NOP.
  - ADD/SUB wrap modulo 2^DATA_W.
  - LDI: rd <= zero-extend {rs1, rs2}, an 8-bit immediate.
  - BNZ: if R[rs1] != 0, PC <= zero-extend {rd field, rs2 field}, truncated to PC_W.
- Reset state:
  - all PCs, registers, counters and pipeline valids = 0; halted = 0.
  - round-robin pointer = NUM_THREADS-1, so the first eligible thread is 0.
  - outputs: fetch_valid=0, fetch_tid=0, imem_addr=0.
  - Reset asserted mid-run discards all in-flight instructions; no retirement is counted in the reset cycle.
- Scheduling:
  - Thread t is eligible when thread_en[t] && !halted[t] && t was not fetched in the previous cycle.
  - The selected thread is the first eligible one scanning upward (with wrap) from pointer+1. On a fetch, pointer <= selected thread.
  - If no thread is eligible: fetch_valid=0, and a bubble (valid=0) enters IF/ID.
  - The one-cycle spacing rule guarantees that a thread's next instruction decodes no earlier than the cycle its predecessor writes back.
- Fetch: imem_addr = PC[sel]. PC[sel] <= PC[sel]+1 unless overridden by a redirect in the same cycle.
- Decode: reads R[tid][rs1] and R[tid][rs2] from the thread's bank.
  - If W writes the same thread and address in the same cycle, D sees the new value (bypass).
- Execute: ALU result, branch decision or halt decision; registered into X/W.
- Writeback: writes rd for ADD..LDI only.
- Redirect: when X/W holds a valid taken BNZ or HALT of thread t:
  - any thread-t instruction in IF/ID is squashed to a bubble;
  - a thread-t fetch in the same cycle is squashed (IF/ID valid=0).
  - taken BNZ: PC[t] <= target, with priority over the +1 increment.
  - HALT: halted[t] <= 1; PC[t] is unchanged; halted[t] is cleared only by reset.
  - Other threads are unaffected.
- Retirement: an instruction retires when it is valid in X/W and its op is 1..7, including a not-taken BNZ.
  - retire_count[t] increments on retirement; squashed instructions and bubbles never count.
  - All counters wrap at 2^32.
- Hazards: no other hazard logic exists; the spacing rule plus the bypass are sufficient.
- thread_en deasserted mid-run stops new fetches only; in-flight instructions complete.

Test Plan:
- Isolation, NUM_THREADS=4, all enabled; each thread runs LDI r1,0x12; LDI r2,0x03; ADD r3,r1,r2; HALT.
  - Required: every bank has r3=0x0015 and halted=4'hF.
  - Required: retire_count=4 per thread.
  - Required: fetch_tid sequence 0,1,2,3,0,... with no duplicates in consecutive cycles.
- Single thread, thread_en=4'b0001:
  - fetch_valid alternates 1,0,1,0.
  - LDI r1,0x05; ADD r2,r1,r1 gives r2=0x000A, which proves the bypass.
- Branch, NUM_THREADS=2:
  - Thread 0 runs LDI r1,1; BNZ r1 ->0x10; LDI r4,0xFF, with LDI r5,0x07 at 0x10.
  - Required: r4 stays 0 (squashed) and r5=7.
  - Required: retire_count[0] excludes the squashed LDI.
  - Thread 1 is unaffected.
- Not-taken branch: BNZ on r1=0 falls through to PC+1 and counts as retired.
- Halt isolation: thread 2 executes HALT at cycle ~10.
  - Required: halted=4'b0100.
  - Required: threads 0,1,3 keep rotating with no bubble slot for thread 2.
  - Required: imem_addr never shows PC[2] afterwards.
- Reset mid-run: assert rst during a taken branch.
  - Required: all outputs and counters are 0 immediately.
  - Required: after release, the first fetch is thread 0 at PC 0.
